// File: rtl/wr_burst_packer.sv
// wr_burst_packer
//   Buffers decompressor result beats (data + byte strobe) in an internal
//   FIFO and writes them back to host memory as bounded DMA write bursts
//   that never cross a 4 KB page. Only one burst is in flight at a time.
//   A burst is requested only once all of its beats are buffered, so the
//   write-data channel never stalls mid-burst on our side.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle job start (ignored while busy)
//   des_addr               job destination (bits [5:0] ignored)
//   decompression_length   job size in bytes
//   in_data/in_strb/in_valid/in_ready   decompressor beat stream
//   dma_wr_req/addr/len/req_ack         burst request channel
//   dma_wr_data/data_strobe/wvalid/ready/wlast   write data channel
//   dma_wr_bready/dma_wr_done           write response channel
//   busy, done             job status (done sticky until next start)
module wr_burst_packer #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH         = 128,
  parameter int MAX_BURST          = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   des_addr,
  input  logic [31:0]                     decompression_length,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   in_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] in_strb,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            dma_wr_req,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   dma_wr_addr,
  output logic [7:0]                      dma_wr_len,
  input  logic                            dma_wr_req_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   dma_wr_data,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] dma_wr_data_strobe,
  output logic                            dma_wr_wvalid,
  input  logic                            dma_wr_ready,
  output logic                            dma_wr_wlast,
  output logic                            dma_wr_bready,
  input  logic                            dma_wr_done,
  output logic                            busy,
  output logic                            done
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int SW     = C_M_AXI_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BL_W   = 9;
  localparam int CMP_W  = (CNT_W > BL_W) ? CNT_W : BL_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_DATA, S_RESP, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [AW-1:0]    r_addr;
  logic [26:0]      r_total;
  logic [26:0]      r_remaining;
  logic [26:0]      r_accepted;
  logic [BL_W-1:0]  r_blen;
  logic [BL_W-1:0]  r_beat;

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [SW+DW-1:0] r_mem [FIFO_DEPTH];

  logic             w_active, w_idle_like, w_start_ok;
  logic             w_push, w_pop;
  logic [26:0]      w_tot_beats;
  logic [6:0]       w_page_beats;
  logic [BL_W-1:0]  w_rem_cap, w_blen;
  logic             w_last_beat, w_resp_last, w_have_burst;
  logic [SW+DW-1:0] w_head;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_active    = !w_idle_like;
  assign w_start_ok  = start && w_idle_like;

  // ceil(len/64); widened so a length near 2^32 cannot wrap
  assign w_tot_beats = 27'((33'(decompression_length) + 33'd63) >> 6);

  // Beats left before the next 4 KB boundary: 1..64
  assign w_page_beats = 7'd64 - {1'b0, r_addr[11:6]};
  assign w_rem_cap    = (r_remaining > 27'(MAX_BURST)) ? BL_W'(MAX_BURST)
                                                       : r_remaining[BL_W-1:0];
  assign w_blen       = (w_rem_cap > BL_W'(w_page_beats)) ? BL_W'(w_page_beats)
                                                          : w_rem_cap;

  assign w_have_burst = CMP_W'(r_count) >= CMP_W'(w_blen);
  assign w_last_beat  = (r_beat == r_blen - BL_W'(1));
  assign w_resp_last  = (r_remaining == 27'(r_blen));

  assign w_push = in_valid && in_ready;
  assign w_pop  = dma_wr_wvalid && dma_wr_ready;
  assign w_head = r_mem[r_rd_ptr];

  // Beats beyond the job's total are refused rather than buffered
  assign in_ready = w_active && (r_count != CNT_W'(FIFO_DEPTH)) &&
                    (r_accepted != r_total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    dma_wr_req         = 1'b0;
    dma_wr_addr        = '0;
    dma_wr_len         = '0;
    dma_wr_wvalid      = 1'b0;
    dma_wr_wlast       = 1'b0;
    dma_wr_data        = '0;
    dma_wr_data_strobe = '0;
    dma_wr_bready      = 1'b0;
    busy               = w_active;
    done               = (r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (w_tot_beats == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (w_have_burst) w_next = S_REQ;
      end
      S_REQ: begin
        dma_wr_req  = 1'b1;
        dma_wr_addr = r_addr;
        dma_wr_len  = 8'(r_blen - BL_W'(1));
        if (dma_wr_req_ack) w_next = S_DATA;
      end
      S_DATA: begin
        dma_wr_wvalid      = 1'b1;
        dma_wr_wlast       = w_last_beat;
        dma_wr_data        = w_head[DW-1:0];
        dma_wr_data_strobe = w_head[SW+DW-1:DW];
        if (dma_wr_ready && w_last_beat) w_next = S_RESP;
      end
      S_RESP: begin
        dma_wr_bready = 1'b1;
        if (dma_wr_done) w_next = w_resp_last ? S_DONE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job and burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_total     <= '0;
      r_remaining <= '0;
      r_accepted  <= '0;
      r_blen      <= '0;
      r_beat      <= '0;
    end else begin
      if (w_start_ok) begin
        r_total     <= w_tot_beats;
        r_remaining <= w_tot_beats;
        r_addr      <= {des_addr[AW-1:6], 6'b0};
        r_accepted  <= '0;
      end else if (w_push) begin
        r_accepted  <= r_accepted + 27'd1;
      end

      // Burst length is frozen here so REQ/DATA see a stable value
      if (r_state == S_WAIT && w_have_burst) r_blen <= w_blen;

      if (r_state == S_REQ) r_beat <= '0;
      else if (w_pop)       r_beat <= r_beat + BL_W'(1);

      if (r_state == S_RESP && dma_wr_done) begin
        r_addr      <= r_addr + (AW'(r_blen) << 6);
        r_remaining <= r_remaining - 27'(r_blen);
      end
    end
  end

  // FIFO pointers/occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_strb, in_data};
  end

endmodule

// File: tb/tb_wr_burst_packer.sv
module tb_wr_burst_packer;

  localparam int DEPTH = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  des_addr;
  logic [31:0]  decompression_length;
  logic [511:0] in_data;
  logic [63:0]  in_strb;
  logic         in_valid, in_ready;
  logic         dma_wr_req;
  logic [63:0]  dma_wr_addr;
  logic [7:0]   dma_wr_len;
  logic         dma_wr_req_ack;
  logic [511:0] dma_wr_data;
  logic [63:0]  dma_wr_data_strobe;
  logic         dma_wr_wvalid, dma_wr_ready, dma_wr_wlast;
  logic         dma_wr_bready, dma_wr_done;
  logic         busy, done;

  always #5 clk = ~clk;

  wr_burst_packer #(
    .C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(512),
    .FIFO_DEPTH(DEPTH), .MAX_BURST(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .des_addr(des_addr),
    .decompression_length(decompression_length),
    .in_data(in_data), .in_strb(in_strb), .in_valid(in_valid), .in_ready(in_ready),
    .dma_wr_req(dma_wr_req), .dma_wr_addr(dma_wr_addr), .dma_wr_len(dma_wr_len),
    .dma_wr_req_ack(dma_wr_req_ack), .dma_wr_data(dma_wr_data),
    .dma_wr_data_strobe(dma_wr_data_strobe), .dma_wr_wvalid(dma_wr_wvalid),
    .dma_wr_ready(dma_wr_ready), .dma_wr_wlast(dma_wr_wlast),
    .dma_wr_bready(dma_wr_bready), .dma_wr_done(dma_wr_done),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] len;
    logic [63:0] addr;
    int          nb;
    logic [63:0] ea [4];
    logic [7:0]  el [4];
    logic [63:0] lstrb;
    int          stall;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] bd(input int j, input int k);
    return {16{8'(j), 24'(k)}};
  endfunction

  function automatic vec_t mk(input logic [31:0] len, input logic [63:0] addr, input int nb,
                              input logic [63:0] a0, input logic [7:0] l0,
                              input logic [63:0] a1, input logic [7:0] l1,
                              input logic [63:0] a2, input logic [7:0] l2,
                              input logic [63:0] lstrb, input int stall);
    vec_t v;
    v.len = len; v.addr = addr; v.nb = nb;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = '0;
    v.el[0] = l0; v.el[1] = l1; v.el[2] = l2; v.el[3] = '0;
    v.lstrb = lstrb; v.stall = stall;
    return v;
  endfunction

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_req"},    dma_wr_req, 0);
    chk({pfx, "_addr"},   dma_wr_addr, 0);
    chk({pfx, "_len"},    dma_wr_len, 0);
    chk({pfx, "_wvalid"}, dma_wr_wvalid, 0);
    chk({pfx, "_wlast"},  dma_wr_wlast, 0);
    chk({pfx, "_data"},   dma_wr_data, 0);
    chk({pfx, "_strb"},   dma_wr_data_strobe, 0);
    chk({pfx, "_bready"}, dma_wr_bready, 0);
    chk({pfx, "_inrdy"},  in_ready, 0);
    chk({pfx, "_busy"},   busy, 0);
    chk({pfx, "_done"},   done, 0);
  endtask

  // Runs one job: acts as decompressor source and DMA write slave at once,
  // deciding all inputs on the falling edge for the next rising edge.
  task automatic run_job(input vec_t v, input int jid);
    int  total, pushed, popped, nb, beat, cyc, req_wait, stall, max_occ;
    bit  fin, last_resp;
    logic [63:0] exp_strb;
    total = int'((64'(v.len) + 64'd63) / 64);
    @(negedge clk);
    start = 1'b1; des_addr = v.addr; decompression_length = v.len;
    @(negedge clk);
    start = 1'b0;
    if (total == 0) begin
      chk($sformatf("j%0d_zero_done", jid), done, 1);
      chk($sformatf("j%0d_zero_busy", jid), busy, 0);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("j%0d_zero_noreq", jid), dma_wr_req, 0);
        @(negedge clk);
      end
      chk($sformatf("j%0d_zero_done_sticky", jid), done, 1);
      return;
    end
    chk($sformatf("j%0d_busy", jid), busy, 1);
    chk($sformatf("j%0d_done_clr", jid), done, 0);
    pushed = 0; popped = 0; nb = 0; beat = 0; cyc = 0; req_wait = 0;
    stall = v.stall; max_occ = 0; fin = 0; last_resp = 0;
    while (!fin && cyc < 5000) begin
      if (pushed - popped > max_occ) max_occ = pushed - popped;
      chk($sformatf("j%0d_inready_c%0d", jid, cyc), in_ready,
          ((pushed - popped) < DEPTH) && (pushed < total));
      // start while busy must be ignored
      start    = (cyc == 3);
      des_addr = (cyc == 3) ? 64'hDEAD_0000 : v.addr;
      // source
      if (pushed < total) begin
        in_valid = 1'b1;
        in_data  = bd(jid, pushed);
        in_strb  = (pushed == total - 1) ? v.lstrb : '1;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) pushed++;
      // request channel: hold off the ack one cycle to see the request stay stable
      dma_wr_req_ack = 1'b0;
      if (dma_wr_req) begin
        if (nb < v.nb) begin
          chk($sformatf("j%0d_b%0d_addr", jid, nb), dma_wr_addr, v.ea[nb]);
          chk($sformatf("j%0d_b%0d_len", jid, nb), dma_wr_len, v.el[nb]);
          chk($sformatf("j%0d_b%0d_buffered", jid, nb),
              (pushed - popped) >= int'(v.el[nb]) + 1, 1);
        end else begin
          chk($sformatf("j%0d_extra_req", jid), dma_wr_req, 0);
        end
        req_wait++;
        if (req_wait >= 2) begin dma_wr_req_ack = 1'b1; req_wait = 0; end
      end
      // data channel
      dma_wr_ready = (stall == 0) && ((cyc % 4) != 3);
      if (stall > 0) stall--;
      if (dma_wr_wvalid && dma_wr_ready) begin
        exp_strb = (popped == total - 1) ? v.lstrb : '1;
        chk($sformatf("j%0d_data%0d", jid, popped), dma_wr_data, bd(jid, popped));
        chk($sformatf("j%0d_strb%0d", jid, popped), dma_wr_data_strobe, exp_strb);
        if (nb < v.nb)
          chk($sformatf("j%0d_wlast%0d", jid, popped), dma_wr_wlast, beat == int'(v.el[nb]));
        popped++;
        beat = dma_wr_wlast ? 0 : beat + 1;
      end
      // response channel
      dma_wr_done = 1'b0;
      if (dma_wr_bready) begin
        dma_wr_done = 1'b1;
        nb++;
        if (nb == v.nb) last_resp = 1;
      end
      @(negedge clk);
      cyc++;
      if (last_resp) begin
        dma_wr_done = 1'b0;
        chk($sformatf("j%0d_done", jid), done, 1);
        chk($sformatf("j%0d_busy_end", jid), busy, 0);
        chk($sformatf("j%0d_inready_end", jid), in_ready, 0);
        chk($sformatf("j%0d_all_beats", jid), popped, total);
        fin = 1;
      end
    end
    if (!fin) chk($sformatf("j%0d_timeout", jid), 0, 1);
    if (v.stall > 0) chk($sformatf("j%0d_fifo_filled", jid), max_occ, DEPTH);
    start = 0; in_valid = 0; dma_wr_ready = 0; dma_wr_req_ack = 0; dma_wr_done = 0;
  endtask

  vec_t vt [9];

  initial begin
    int pushed, cyc;
    rst_n = 1'b0; start = 0; des_addr = '0; decompression_length = '0;
    in_data = '0; in_strb = '0; in_valid = 0;
    dma_wr_req_ack = 0; dma_wr_ready = 0; dma_wr_done = 0;

    vt[0] = mk(128,   64'h1000, 1, 64'h1000, 1,  0, 0, 0, 0, '1, 0);
    vt[1] = mk(8192,  64'h0,    2, 64'h0, 63, 64'h1000, 63, 0, 0, '1, 0);
    vt[2] = mk(256,   64'hFC0,  2, 64'hFC0, 0, 64'h1000, 2, 0, 0, '1, 0);
    vt[3] = mk(100,   64'h2000, 1, 64'h2000, 1, 0, 0, 0, 0, 64'hFFFFFFFFF0000000, 0);
    vt[4] = mk(10240, 64'h0,    3, 64'h0, 63, 64'h1000, 63, 64'h2000, 31, '1, 400);
    vt[5] = mk(0,     64'h4000, 0, 0, 0, 0, 0, 0, 0, '1, 0);
    vt[6] = mk(192,   64'h7F80, 2, 64'h7F80, 1, 64'h8000, 0, 0, 0, '1, 0);
    vt[7] = mk(64,    64'h1023, 1, 64'h1000, 0, 0, 0, 0, 0, 64'h0000_0000_0000_00FF, 0);
    vt[8] = mk(65,    64'h5000, 1, 64'h5000, 1, 0, 0, 0, 0, 64'h1, 0);

    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("idle");

    for (int i = 0; i < 9; i++) run_job(vt[i], i + 1);

    // Reset in the middle of a burst's data phase
    @(negedge clk);
    start = 1; des_addr = 64'h0; decompression_length = 8192;
    @(negedge clk);
    start = 0; pushed = 0; cyc = 0;
    while (pushed < 64 && cyc < 300) begin
      in_valid = 1'b1; in_data = bd(30, pushed); in_strb = '1;
      if (in_ready) pushed++;
      @(negedge clk); cyc++;
    end
    in_valid = 0;
    cyc = 0;
    while (!dma_wr_req && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rst_req_seen", dma_wr_req, 1);
    dma_wr_req_ack = 1;
    @(negedge clk);
    dma_wr_req_ack = 0; dma_wr_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_data", dma_wr_wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    @(negedge clk);
    dma_wr_ready = 0;
    chk_outputs_zero("midrst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_job(mk(64, 64'h3000, 1, 64'h3000, 0, 0, 0, 0, 0, '1, 0), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something hangs outside the bounded loops
  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wr_burst_packer.md
Name: wr_burst_packer

Overview:
- Sits directly downstream of the decompressor output ports.
- Buffers 512-bit result beats with byte strobes in an internal FIFO.
- Carves them into AXI-compliant write bursts: bounded length, no 4 KB crossing.
- Drives the DMA write request, data and response handshakes until a job's full decompressed length has been written back to host memory.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, host address width
C_M_AXI_DATA_WIDTH, 512, beat width in bits (64 bytes per beat)
FIFO_DEPTH, 128, beat entries in the internal buffer (power of 2, at least MAX_BURST)
MAX_BURST, 64, maximum beats per burst (at most 256)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start pulse
des_addr  in  C_M_AXI_ADDR_WIDTH  job destination address; bits [5:0] must be zero and are ignored
decompression_length  in  32  job output size in bytes
in_data  in  C_M_AXI_DATA_WIDTH  decompressor beat, already in DMA byte order
in_strb  in  64  byte-valid mask for in_data
in_valid  in  1  in_data/in_strb valid
in_ready  out  1  beat accepted when in_valid & in_ready
dma_wr_req  out  1  burst request
dma_wr_addr  out  C_M_AXI_ADDR_WIDTH  burst start address
dma_wr_len  out  8  burst beats minus one
dma_wr_req_ack  in  1  request accepted
dma_wr_data  out  C_M_AXI_DATA_WIDTH  write beat
dma_wr_data_strobe  out  64  write byte strobe
dma_wr_wvalid  out  1  write beat valid
dma_wr_ready  in  1  beat taken when wvalid & ready
dma_wr_wlast  out  1  last beat of current burst
dma_wr_bready  out  1  ready for write response
dma_wr_done  in  1  write response received (bvalid)
busy  out  1  job in progress
done  out  1  job complete, sticky until next start

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset is asynchronous; asserting rst_n low mid-job discards FIFO contents and any outstanding burst immediately.
- Job setup, when start is sampled in IDLE or DONE:
  - latch total_beats = ceil(decompression_length/64), 27 bits;
  - latch addr = des_addr with [5:0] forced to 0;
  - clear done, set busy.
- start while busy is ignored.
- Zero-length job (decompression_length = 0): go to DONE on the next cycle with no bus activity.
- in_ready = FIFO not full, in all states except IDLE/DONE, where it is 0.
- FIFO write latency is 1 cycle: a beat accepted at cycle N is readable at N+1.
- Burst length B = min(MAX_BURST, remaining_beats, (4096 - addr[11:0])/64).
- A burst is requested only when FIFO count >= B. A burst is never started until its data is fully buffered, so wvalid never stalls mid-burst.
- State REQ: dma_wr_req=1, dma_wr_addr=addr, dma_wr_len=B-1.
  - Hold all three stable until dma_wr_req_ack; then go to DATA.
- State DATA: dma_wr_wvalid=1 with FIFO head data/strobe.
  - Pop the head on each wvalid & dma_wr_ready.
  - dma_wr_wlast=1 on beat B.
  - After the last beat handshake, go to RESP.
- State RESP: dma_wr_bready=1.
  - On dma_wr_done: addr += B*64; remaining_beats -= B.
  - If remaining_beats becomes 0, go to DONE; else go to WAIT.
- State WAIT: evaluate B and go to REQ once the FIFO holds B beats.
- State DONE: done=1, busy=0. Beats are still accepted into the FIFO only in WAIT/REQ/DATA/RESP.
- Only one burst is outstanding at a time.
- Simultaneous FIFO push and pop in DATA keeps the count unchanged.
- FIFO full deasserts in_ready the same cycle the count reaches FIFO_DEPTH.
- Extra input beats beyond total_beats are a protocol error and are not accepted: in_ready drops once accepted beats = total_beats.
- FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Length 128 B, des_addr 0x1000, 2 beats pushed -> one request addr 0x1000 len 1, wlast on 2nd beat, done 1 cycle after dma_wr_done.
- Length 8192 B, des_addr 0x0 -> two bursts: 0x0 len 63, then 0x1000 len 63; done after second response.
- des_addr 0xFC0, length 256 B -> bursts 0xFC0 len 0, then 0x1000 len 2; no 4 KB crossing.
- Length 100 B -> one burst len 1; the strobe of beat 2 passes through unchanged (0xFFFFFFFFF0000000 pattern as supplied).
- Hold dma_wr_ready=0 during a 160-beat job -> in_ready deasserts when 128 beats are buffered; no data lost once ready resumes; all addresses and lengths correct.
- Assert rst_n low mid-DATA, then start a 64 B job -> all outputs 0 during reset; the new job completes with a single burst len 0.
- Length 0 -> done high 1 cycle after start; dma_wr_req never asserts.
